// File: rtl/histo_pkg.sv
// Shared definitions for the histogram frame sequencer.
//   state_t  : sequencer phase encoding, also driven out on oPhase
//   *_DEF    : default geometry of the histogram RAM
//   sat_add  : unsigned add that clamps at 2^w-1 (w <= 32)
package histo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SNAP   = 3'd3,
    ST_CLEAR  = 3'd4
  } state_t;

  localparam int BINS_DEF   = 256;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 20;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/histo_cum_scan.sv
// Cumulative scan datapath used while the sequencer sweeps the histogram.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   snap         : sequencer is in the SNAP phase
//   k            : SNAP step counter (0..BINS); bin j=k-1 is on q for k>=1
//   q            : histogram RAM read data (1-cycle latency)
//   disp_*       : display RAM write port (cumulative RAM shares addr/en)
//   cum_data     : cumulative RAM write data (running saturated sum)
//   pend_next    : threshold bin including the bin on q this cycle
module histo_cum_scan
  import histo_pkg::*;
#(
  parameter int BINS   = BINS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int THRESH = 192000,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snap,
  input  logic [CNT_W-1:0]  k,
  input  logic [DATA_W-1:0] q,
  output logic              disp_wen,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic [DATA_W-1:0] cum_data,
  output logic [ADDR_W-1:0] pend_next
);

  localparam logic [DATA_W-1:0] THR      = DATA_W'(THRESH);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);

  logic              vld_p0;
  logic [ADDR_W-1:0] j;
  logic [DATA_W-1:0] cum_nx;
  logic              hit;
  logic [DATA_W-1:0] cum_p1;
  logic              found_p1;
  logic [ADDR_W-1:0] pend_p1;

  // stage p0: bin j arrives from the RAM, combine with running sum
  assign vld_p0 = snap && (k != '0);
  assign j      = ADDR_W'(k - CNT_W'(1));
  assign cum_nx = DATA_W'(sat_add(32'(cum_p1), 32'(q), DATA_W));
  // Only the first crossing counts; later bins keep the captured index.
  assign hit       = vld_p0 && !found_p1 && (cum_nx > THR);
  assign pend_next = hit ? j : pend_p1;

  assign disp_wen  = vld_p0;
  assign disp_addr = vld_p0 ? j      : '0;
  assign disp_data = vld_p0 ? q      : '0;
  assign cum_data  = vld_p0 ? cum_nx : '0;

  // stage p1: running sum, found flag and pending threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cum_p1   <= '0;
      found_p1 <= 1'b0;
      pend_p1  <= LAST_BIN;
    end else if (snap) begin
      if (k == '0) begin
        // k=0 is the read-issue cycle only: start a fresh scan.
        cum_p1   <= '0;
        found_p1 <= 1'b0;
        pend_p1  <= LAST_BIN;
      end else begin
        cum_p1   <= cum_nx;
        found_p1 <= found_p1 | hit;
        pend_p1  <= pend_next;
      end
    end
  end

endmodule

// File: rtl/histo_frame_seq.sv
// Per-frame phase sequencer and port arbiter for the histogram RAM.
// IDLE -> ACCUM (accumulator owns the RAM) -> SETTLE (drain) -> SNAP (scan
// to display/cumulative RAMs, latch threshold) -> CLEAR (zero all bins).
// Ports:
//   iPclk, iRST_N       : clock, asynchronous active-low reset
//   iFval               : frame valid from capture
//   iAcc_*              : pixel accumulator read-modify-write port
//   iHist_Q             : histogram RAM read data, 1-cycle latency
//   oHist_*             : histogram RAM ports
//   oDisp_*, oCum_Wr_Data : display / cumulative RAM write ports
//   oThresh             : latched threshold bin
//   oPhase              : current state encoding
//   oFrame_Done         : pulse on the final CLEAR cycle
//   oSkip_Cnt           : frames missed while busy (saturating)
module histo_frame_seq
  import histo_pkg::*;
#(
  parameter int BINS   = BINS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SETTLE = 4,
  parameter int THRESH = 192000
) (
  input  logic              iPclk,
  input  logic              iRST_N,
  input  logic              iFval,
  input  logic [ADDR_W-1:0] iAcc_Rd_Addr,
  input  logic [ADDR_W-1:0] iAcc_Wr_Addr,
  input  logic [DATA_W-1:0] iAcc_Wr_Data,
  input  logic              iAcc_Wen,
  input  logic [DATA_W-1:0] iHist_Q,
  output logic [ADDR_W-1:0] oHist_Rd_Addr,
  output logic [ADDR_W-1:0] oHist_Wr_Addr,
  output logic [DATA_W-1:0] oHist_Wr_Data,
  output logic              oHist_Wen,
  output logic [ADDR_W-1:0] oDisp_Wr_Addr,
  output logic [DATA_W-1:0] oDisp_Wr_Data,
  output logic              oDisp_Wen,
  output logic [DATA_W-1:0] oCum_Wr_Data,
  output logic [ADDR_W-1:0] oThresh,
  output logic [2:0]        oPhase,
  output logic              oFrame_Done,
  output logic [7:0]        oSkip_Cnt
);

  // One extra bit so SNAP can count to BINS (the last read-data cycle).
  // SETTLE must not exceed BINS.
  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] SNAP_LAST = CNT_W'(BINS);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(BINS - 1);
  localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(SETTLE - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              fval_q;
  logic              rise, fall;
  logic              pass;
  logic              clr_wen;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] snap_rd;
  logic              done;
  logic [ADDR_W-1:0] thresh_q;
  logic [7:0]        skip_q;
  logic              busy;

  logic              scan_wen;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic [DATA_W-1:0] scan_cum;
  logic [ADDR_W-1:0] pend_next;

  assign rise = iFval & ~fval_q;
  assign fall = ~iFval & fval_q;
  assign busy = (state == ST_SETTLE) || (state == ST_SNAP) || (state == ST_CLEAR);

  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_CLEAR;
      cnt      <= '0;
      fval_q   <= 1'b0;
      thresh_q <= '0;
      skip_q   <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      fval_q <= iFval;
      if (state == ST_SNAP && cnt == SNAP_LAST)
        thresh_q <= pend_next;
      if (rise && busy && skip_q != 8'hFF)
        skip_q <= skip_q + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pass     = 1'b0;
    clr_wen  = 1'b0;
    clr_addr = '0;
    snap_rd  = '0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (rise) state_nx = ST_ACCUM;
      end
      ST_ACCUM: begin
        pass = 1'b1;
        if (fall) begin
          state_nx = ST_SETTLE;
          cnt_nx   = '0;
        end
      end
      ST_SETTLE: begin
        // Keep the accumulator connected so in-flight writes land.
        pass = 1'b1;
        if (cnt == SET_LAST) begin
          state_nx = ST_SNAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_SNAP: begin
        if (cnt != SNAP_LAST) snap_rd = ADDR_W'(cnt);
        if (cnt == SNAP_LAST) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        clr_wen  = 1'b1;
        clr_addr = ADDR_W'(cnt);
        if (cnt == CLR_LAST) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  histo_cum_scan #(
    .BINS   (BINS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .THRESH (THRESH),
    .CNT_W  (CNT_W)
  ) u_scan (
    .clk       (iPclk),
    .rst_n     (iRST_N),
    .snap      (state == ST_SNAP),
    .k         (cnt),
    .q         (iHist_Q),
    .disp_wen  (scan_wen),
    .disp_addr (scan_addr),
    .disp_data (scan_data),
    .cum_data  (scan_cum),
    .pend_next (pend_next)
  );

  // Outputs are forced low while reset is held, even though the state
  // register already sits in CLEAR, so no RAM sees a write during reset.
  assign oHist_Rd_Addr = iRST_N ? (pass ? iAcc_Rd_Addr : snap_rd)  : '0;
  assign oHist_Wr_Addr = iRST_N ? (pass ? iAcc_Wr_Addr : clr_addr) : '0;
  assign oHist_Wr_Data = (iRST_N && pass) ? iAcc_Wr_Data : '0;
  assign oHist_Wen     = iRST_N & (pass ? iAcc_Wen : clr_wen);
  assign oDisp_Wen     = iRST_N & scan_wen;
  assign oDisp_Wr_Addr = iRST_N ? scan_addr : '0;
  assign oDisp_Wr_Data = iRST_N ? scan_data : '0;
  assign oCum_Wr_Data  = iRST_N ? scan_cum  : '0;
  assign oFrame_Done   = iRST_N & done;
  assign oPhase        = iRST_N ? 3'(state) : 3'd0;
  assign oThresh       = thresh_q;
  assign oSkip_Cnt     = skip_q;

endmodule

// File: tb/tb_histo_frame_seq.sv
module tb_histo_frame_seq;

  logic        iPclk = 1'b0;
  logic        iRST_N;
  logic        iFval;
  logic [7:0]  iAcc_Rd_Addr;
  logic [7:0]  iAcc_Wr_Addr;
  logic [19:0] iAcc_Wr_Data;
  logic        iAcc_Wen;
  logic [19:0] iHist_Q;
  logic [7:0]  oHist_Rd_Addr;
  logic [7:0]  oHist_Wr_Addr;
  logic [19:0] oHist_Wr_Data;
  logic        oHist_Wen;
  logic [7:0]  oDisp_Wr_Addr;
  logic [19:0] oDisp_Wr_Data;
  logic        oDisp_Wen;
  logic [19:0] oCum_Wr_Data;
  logic [7:0]  oThresh;
  logic [2:0]  oPhase;
  logic        oFrame_Done;
  logic [7:0]  oSkip_Cnt;

  histo_frame_seq dut (
    .iPclk         (iPclk),
    .iRST_N        (iRST_N),
    .iFval         (iFval),
    .iAcc_Rd_Addr  (iAcc_Rd_Addr),
    .iAcc_Wr_Addr  (iAcc_Wr_Addr),
    .iAcc_Wr_Data  (iAcc_Wr_Data),
    .iAcc_Wen      (iAcc_Wen),
    .iHist_Q       (iHist_Q),
    .oHist_Rd_Addr (oHist_Rd_Addr),
    .oHist_Wr_Addr (oHist_Wr_Addr),
    .oHist_Wr_Data (oHist_Wr_Data),
    .oHist_Wen     (oHist_Wen),
    .oDisp_Wr_Addr (oDisp_Wr_Addr),
    .oDisp_Wr_Data (oDisp_Wr_Data),
    .oDisp_Wen     (oDisp_Wen),
    .oCum_Wr_Data  (oCum_Wr_Data),
    .oThresh       (oThresh),
    .oPhase        (oPhase),
    .oFrame_Done   (oFrame_Done),
    .oSkip_Cnt     (oSkip_Cnt)
  );

  always #5 iPclk = ~iPclk;

  // Histogram RAM: synchronous write, registered read.
  logic [19:0] hmem [256];
  always @(posedge iPclk) begin
    if (oHist_Wen) hmem[oHist_Wr_Addr] <= oHist_Wr_Data;
    iHist_Q <= hmem[oHist_Rd_Addr];
  end

  // Monitor: display/cumulative RAM images, CLEAR sweep order, stray writes.
  logic [19:0] disp_mem [256];
  logic [19:0] cum_mem  [256];
  int snap_w = 0, last_snap_w = 0;
  int clr_idx = 0, clr_bad = 0, sweep_cnt = 0, sweep_bad = 0;
  int done_cnt = 0, bad_wen = 0;
  logic clr_err;
  assign clr_err = (oHist_Wr_Addr != 8'(clr_idx)) || (oHist_Wr_Data != 20'd0);

  always @(negedge iPclk) begin
    if (oDisp_Wen) begin
      disp_mem[oDisp_Wr_Addr] <= oDisp_Wr_Data;
      cum_mem[oDisp_Wr_Addr]  <= oCum_Wr_Data;
    end
    if (oPhase == 3'd3) begin
      if (oDisp_Wen) snap_w <= snap_w + 1;
    end else if (snap_w != 0) begin
      last_snap_w <= snap_w;
      snap_w      <= 0;
    end
    if (oPhase == 3'd4 && oHist_Wen) begin
      if (clr_err) clr_bad <= clr_bad + 1;
      clr_idx <= clr_idx + 1;
    end else if (oPhase != 3'd4) begin
      clr_idx <= 0;
      clr_bad <= 0;
    end
    if (oFrame_Done) begin
      sweep_cnt <= clr_idx + 1;
      sweep_bad <= clr_bad + (clr_err ? 1 : 0);
      done_cnt  <= done_cnt + 1;
    end
    if (oHist_Wen && oPhase != 3'd1 && oPhase != 3'd2 && oPhase != 3'd4)
      bad_wen <= bad_wen + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iPclk);
      if (oFrame_Done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_phase(input logic [2:0] p, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iPclk);
      if (oPhase == p) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One accumulator write cycle; optionally check the ACCUM pass-through.
  task automatic acc_write(input int a, input int v, input bit pchk);
    iAcc_Rd_Addr = 8'(a);
    iAcc_Wr_Addr = 8'(a);
    iAcc_Wr_Data = 20'(v);
    iAcc_Wen     = 1'b1;
    if (pchk) begin
      #1;
      chk("pass_phase",   int'(oPhase), 1);
      chk("pass_wen",     int'(oHist_Wen), 1);
      chk("pass_wr_addr", int'(oHist_Wr_Addr), a);
      chk("pass_wr_data", int'(oHist_Wr_Data), v);
      chk("pass_rd_addr", int'(oHist_Rd_Addr), a);
    end
    @(posedge iPclk); #1;
  endtask

  // kind: 0 no writes, 1 bin a0=v0, 2 bins a0=v0 and a1=v1, 3 all bins = v0
  typedef struct {
    int kind; int a0; int v0; int a1; int v1;
    int thr;
    int c0; int e0; int c1; int e1; int c2; int e2;
    int da; int de;
  } vec_t;

  task automatic run_frame(input vec_t v, input int prev_thr);
    bit ok;
    int d0;
    d0 = done_cnt;
    @(posedge iPclk); #1; iFval = 1'b1;
    @(posedge iPclk); #1;
    case (v.kind)
      1: acc_write(v.a0, v.v0, 1'b1);
      2: begin acc_write(v.a0, v.v0, 1'b0); acc_write(v.a1, v.v1, 1'b0); end
      3: for (int b = 0; b < 256; b++) acc_write(b, v.v0, 1'b0);
      default: @(posedge iPclk);
    endcase
    #1;
    iAcc_Wen = 1'b0;
    iFval    = 1'b0;
    wait_phase(3'd3, 50, ok);
    chk("snap_reached", int'(ok), 1);
    chk("thr_hold_in_snap", int'(oThresh), prev_thr);
    wait_done(1000, ok);
    chk("frame_done_seen", int'(ok), 1);
    repeat (2) @(negedge iPclk);
    chk("thresh", int'(oThresh), v.thr);
    chk("cum_c0", int'(cum_mem[8'(v.c0)]), v.e0);
    chk("cum_c1", int'(cum_mem[8'(v.c1)]), v.e1);
    chk("cum_c2", int'(cum_mem[8'(v.c2)]), v.e2);
    chk("disp",   int'(disp_mem[8'(v.da)]), v.de);
    chk("snap_writes", last_snap_w, 256);
    chk("clear_count", sweep_cnt, 256);
    chk("clear_order", sweep_bad, 0);
    chk("done_pulses", done_cnt - d0, 1);
    chk("idle_after",  int'(oPhase), 0);
  endtask

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int prev_thr;
    vecs[0] = '{1, 10, 384000, 0, 0, 10,   9, 0, 10, 384000, 255, 384000, 10, 384000};
    vecs[1] = '{3, 0, 1500, 0, 0, 128,     127, 192000, 128, 193500, 255, 384000, 5, 1500};
    vecs[2] = '{2, 0, 1048575, 1, 5, 0,    0, 1048575, 1, 1048575, 255, 1048575, 1, 5};
    vecs[3] = '{1, 200, 192001, 0, 0, 200, 199, 0, 200, 192001, 255, 192001, 0, 0};
    vecs[4] = '{1, 200, 192000, 0, 0, 255, 199, 0, 200, 192000, 255, 192000, 200, 192000};
    vecs[5] = '{0, 0, 0, 0, 0, 255,        0, 0, 128, 0, 255, 0, 200, 0};

    iRST_N = 1'b0; iFval = 1'b0; iAcc_Wen = 1'b0;
    iAcc_Rd_Addr = '0; iAcc_Wr_Addr = '0; iAcc_Wr_Data = '0;
    repeat (3) @(posedge iPclk); #1;
    chk("rst_hist_wen", int'(oHist_Wen), 0);
    chk("rst_disp_wen", int'(oDisp_Wen), 0);
    chk("rst_thresh",   int'(oThresh), 0);
    chk("rst_skip",     int'(oSkip_Cnt), 0);
    chk("rst_done",     int'(oFrame_Done), 0);
    chk("rst_phase",    int'(oPhase), 0);

    // Post-reset CLEAR sweep.
    iRST_N = 1'b1;
    wait_done(400, ok);
    chk("init_done_seen", int'(ok), 1);
    repeat (20) @(negedge iPclk);
    chk("init_clear_count", sweep_cnt, 256);
    chk("init_clear_order", sweep_bad, 0);
    chk("init_done_pulses", done_cnt, 1);
    chk("init_idle", int'(oPhase), 0);

    prev_thr = 0;
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], prev_thr);
      prev_thr = vecs[i].thr;
    end

    // A rise during SNAP is counted as skipped and never accumulated.
    @(posedge iPclk); #1; iFval = 1'b1;
    @(posedge iPclk); #1;
    acc_write(50, 7, 1'b0);
    iAcc_Wen = 1'b0; iFval = 1'b0;
    wait_phase(3'd3, 50, ok);
    chk("skip_snap_reached", int'(ok), 1);
    repeat (20) @(posedge iPclk); #1;
    iFval = 1'b1;
    iAcc_Rd_Addr = 8'd60; iAcc_Wr_Addr = 8'd60; iAcc_Wr_Data = 20'd999; iAcc_Wen = 1'b1;
    wait_done(1000, ok);
    chk("skip_done_seen", int'(ok), 1);
    repeat (2) @(negedge iPclk);
    chk("skip_cnt", int'(oSkip_Cnt), 1);
    chk("skip_thresh", int'(oThresh), 255);
    chk("skip_clear_order", sweep_bad, 0);
    repeat (5) @(negedge iPclk);
    chk("skip_stay_idle", int'(oPhase), 0);
    chk("skip_idle_wen", int'(oHist_Wen), 0);
    @(posedge iPclk); #1;
    iAcc_Wen = 1'b0; iFval = 1'b0;
    repeat (3) @(posedge iPclk); #1;
    iFval = 1'b1;
    @(posedge iPclk);
    @(negedge iPclk);
    chk("next_rise_accum", int'(oPhase), 1);
    @(posedge iPclk); #1;
    acc_write(60, 250000, 1'b1);
    iAcc_Wen = 1'b0; iFval = 1'b0;
    wait_done(1000, ok);
    chk("after_skip_done", int'(ok), 1);
    repeat (2) @(negedge iPclk);
    chk("after_skip_thresh", int'(oThresh), 60);
    chk("after_skip_cum59", int'(cum_mem[59]), 0);
    chk("after_skip_cum60", int'(cum_mem[60]), 250000);
    chk("after_skip_disp60", int'(disp_mem[60]), 250000);
    chk("after_skip_skipcnt", int'(oSkip_Cnt), 1);

    // Asynchronous reset in the middle of SNAP (k=100, j=99).
    @(posedge iPclk); #1; iFval = 1'b1;
    @(posedge iPclk); #1;
    acc_write(10, 384000, 1'b0);
    iAcc_Wen = 1'b0; iFval = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge iPclk);
      if (oPhase == 3'd3 && oDisp_Wen && oDisp_Wr_Addr == 8'd99) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_snap_k100", int'(ok), 1);
    #1 iRST_N = 1'b0;
    #1;
    chk("arst_hist_wen",  int'(oHist_Wen), 0);
    chk("arst_hist_rd",   int'(oHist_Rd_Addr), 0);
    chk("arst_disp_wen",  int'(oDisp_Wen), 0);
    chk("arst_disp_addr", int'(oDisp_Wr_Addr), 0);
    chk("arst_cum_data",  int'(oCum_Wr_Data), 0);
    chk("arst_thresh",    int'(oThresh), 0);
    chk("arst_skip",      int'(oSkip_Cnt), 0);
    chk("arst_phase",     int'(oPhase), 0);
    @(posedge iPclk); @(posedge iPclk); #1;
    iRST_N = 1'b1;
    #1;
    chk("arst_clear_phase", int'(oPhase), 4);
    chk("arst_clear_wen",   int'(oHist_Wen), 1);
    chk("arst_clear_addr0", int'(oHist_Wr_Addr), 0);
    wait_done(400, ok);
    chk("arst_done_seen", int'(ok), 1);
    repeat (2) @(negedge iPclk);
    chk("arst_clear_count", sweep_cnt, 256);
    chk("arst_clear_order", sweep_bad, 0);
    chk("arst_thresh_after", int'(oThresh), 0);
    chk("arst_idle", int'(oPhase), 0);
    chk("no_stray_wen", bad_wen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
